// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Latency: n/a (package only; no logic).
// Backpressure: n/a.
// Contents: read-mode constants, occupancy-counter width helper, parameter legality helper.
package fifo_pkg;

  // Read-mode selection for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy counter width: one extra bit so DEPTH itself is representable.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two and at least 2.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from raddr.
// Backpressure: none; the caller gates we.
// Ports: clk, we (write strobe), waddr/wdat (write address/data), raddr/rdat (read address/data).
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdat,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdat
);

  // Contents are intentionally not reset; occupancy tracking makes stale words invisible.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read, flush and sticky errors.
// Latency: standard mode write-to-read 2 cycles, data 1 cycle after rd_en; FWFT shows a new word 1 cycle after the write.
// Backpressure: writes dropped when full unless a pop happens in the same cycle; drops/empty reads set sticky flags.
// Ports: clk, rst (sync, active-high), clr (sync flush), wr_en/buf_in (write), rd_en/buf_out (read),
//        buf_empty/buf_full/almost_empty/almost_full (occupancy decodes), fifo_counter, overflow/underflow (sticky).
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         buf_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         buf_out,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   fifo_counter,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cw(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Parameter legality, checked once at elaboration.
  if (!(fifo_depth_ok(DEPTH) && (WIDTH >= 1) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH) &&
        ((FWFT == FIFO_STD) || (FWFT == FIFO_FWFT)))) begin : g_param_check
    $error("fifo_sync_param: illegal parameters (DEPTH pow2>=2, WIDTH>=1, AE_LEVEL<AF_LEVEL<=DEPTH, FWFT 0/1)");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf_q;
  logic             udf_q;
  logic             rd_ok;
  logic             wr_ok;
  logic             mem_we;
  logic [WIDTH-1:0] rd_dat;

  // Flags decode the registered occupancy only.
  assign buf_empty    = (count == '0);
  assign buf_full     = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);
  assign fifo_counter = count;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
  assign rd_ok = rd_en && !buf_empty;
  assign wr_ok = wr_en && (!buf_full || rd_ok);

  // rst and clr discard any concurrent write so the array never sees it.
  assign mem_we = wr_ok && !rst && !clr;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdat  (buf_in),
    .raddr (rd_ptr),
    .rdat  (rd_dat)
  );

  // Pointer, occupancy and sticky error state. Priority: rst > clr > wr/rd.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (rd_en && !rd_ok) begin
        udf_q <= 1'b1;
      end
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is shown directly; zero when nothing is queued (also covers flush/reset).
    assign buf_out = buf_empty ? '0 : rd_dat;
  end else begin : g_std
    logic [WIDTH-1:0] out_q;

    // Registered read: capture the head word on a successful pop, hold otherwise.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        out_q <= '0;
      end else if (rd_ok) begin
        out_q <= rd_dat;
      end
    end

    assign buf_out = out_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] din;

  // Instance A: defaults, standard mode, 8 x 64
  logic [7:0] a_out;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [6:0] a_cnt;

  // Instance B: standard mode, 8 x 8 for pointer wrap
  logic [7:0] b_out;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [3:0] b_cnt;

  // Instance C: FWFT, 16 x 64
  logic [15:0] c_out;
  logic        c_empty, c_full, c_ae, c_af, c_ovf, c_udf;
  logic [6:0]  c_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_sync_param u_a (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .buf_in(din[7:0]), .rd_en(rd_en),
    .buf_out(a_out), .buf_empty(a_empty), .buf_full(a_full), .almost_empty(a_ae),
    .almost_full(a_af), .fifo_counter(a_cnt), .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_sync_param #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .buf_in(din[7:0]), .rd_en(rd_en),
    .buf_out(b_out), .buf_empty(b_empty), .buf_full(b_full), .almost_empty(b_ae),
    .almost_full(b_af), .fifo_counter(b_cnt), .overflow(b_ovf), .underflow(b_udf)
  );

  fifo_sync_param #(.WIDTH(16), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .buf_in(din), .rd_en(rd_en),
    .buf_out(c_out), .buf_empty(c_empty), .buf_full(c_full), .almost_empty(c_ae),
    .almost_full(c_af), .fifo_counter(c_cnt), .overflow(c_ovf), .underflow(c_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_out"},   32'(a_out),   32'h0);
    chk({tag, "_cnt"},   32'(a_cnt),   32'd0);
    chk({tag, "_empty"}, 32'(a_empty), 32'd1);
    chk({tag, "_ae"},    32'(a_ae),    32'd1);
    chk({tag, "_full"},  32'(a_full),  32'd0);
    chk({tag, "_af"},    32'(a_af),    32'd0);
    chk({tag, "_ovf"},   32'(a_ovf),   32'd0);
    chk({tag, "_udf"},   32'(a_udf),   32'd0);
  endtask

  initial begin
    idle();
    din = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_a_reset("rst");

    // 1: four writes then four reads, standard mode
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      din   = 16'(8'h11 + i);
      step();
      chk("t1_wcnt", 32'(a_cnt), 32'(i + 1));
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_rdat", 32'(a_out), 32'(8'h11 + i));
      chk("t1_rcnt", 32'(a_cnt), 32'(3 - i));
    end
    idle();
    step();
    chk("t1_empty", 32'(a_empty), 32'd1);
    chk("t1_hold",  32'(a_out),   32'h14);

    // 2: fill 64, overflow, then simultaneous write+read while full
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1;
      din   = 16'(i + 1);
      step();
      chk("t2_cnt",  32'(a_cnt),  32'(i + 1));
      chk("t2_af",   32'(a_af),   32'(i >= 59));
      chk("t2_full", 32'(a_full), 32'(i == 63));
    end
    din = 16'h00EE;
    step();
    chk("t2_ovf",     32'(a_ovf), 32'd1);
    chk("t2_ovf_cnt", 32'(a_cnt), 32'd64);
    rd_en = 1'b1;
    din   = 16'h00C3;
    step();
    chk("t2_wr_rd_cnt", 32'(a_cnt), 32'd64);
    chk("t2_wr_rd_out", 32'(a_out), 32'h01);
    chk("t2_ovf_stky",  32'(a_ovf), 32'd1);
    wr_en = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk("t2_drain", 32'(a_out), (k < 63) ? 32'(k + 2) : 32'hC3);
    end
    rd_en = 1'b0;
    chk("t2_drain_empty", 32'(a_empty), 32'd1);

    // 3: underflow on empty read, then write+read on empty
    rd_en = 1'b1;
    step();
    chk("t3_udf",  32'(a_udf), 32'd1);
    chk("t3_cnt",  32'(a_cnt), 32'd0);
    chk("t3_hold", 32'(a_out), 32'hC3);
    wr_en = 1'b1;
    din   = 16'h00A5;
    step();
    chk("t3_wr_cnt",   32'(a_cnt),   32'd1);
    chk("t3_wr_empty", 32'(a_empty), 32'd0);
    chk("t3_wr_hold",  32'(a_out),   32'hC3);
    wr_en = 1'b0;
    step();
    chk("t3_rd_a5", 32'(a_out), 32'hA5);
    chk("t3_udf2",  32'(a_udf), 32'd1);
    idle();

    // 6a: 5 words queued with overflow still set, then clr with a concurrent write
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din   = 16'(8'h21 + i);
      step();
    end
    chk("t6_pre_cnt", 32'(a_cnt), 32'd5);
    chk("t6_pre_ovf", 32'(a_ovf), 32'd1);
    clr = 1'b1;
    din = 16'h0077;
    step();
    clr   = 1'b0;
    wr_en = 1'b0;
    chk("t6_clr_cnt",   32'(a_cnt),   32'd0);
    chk("t6_clr_empty", 32'(a_empty), 32'd1);
    chk("t6_clr_ovf",   32'(a_ovf),   32'd0);
    chk("t6_clr_udf",   32'(a_udf),   32'd0);
    chk("t6_clr_out",   32'(a_out),   32'h0);
    step();
    chk("t6_clr_nowr", 32'(a_cnt), 32'd0);
    wr_en = 1'b1;
    din   = 16'h0099;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t6_post_clr_data", 32'(a_out), 32'h99);

    // 6b: overflow set with 5 words queued, then rst mid-burst
    for (int i = 0; i < 65; i++) begin
      wr_en = 1'b1;
      din   = 16'(i + 1);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 59; i++) begin
      step();
    end
    rd_en = 1'b0;
    chk("t6b_pre_cnt", 32'(a_cnt), 32'd5);
    chk("t6b_pre_ovf", 32'(a_ovf), 32'd1);
    chk("t6b_pre_out", 32'(a_out), 32'h3B);
    wr_en = 1'b1;
    din   = 16'h0055;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk_a_reset("t6b_rst");

    // 4: DEPTH=8 stream of 20 words with a read every cycle after the first write
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      wr_en = (k < 20);
      rd_en = (k > 0);
      din   = 16'(k);
      step();
      if (k > 0) begin
        chk("t4_stream", 32'(b_out), 32'(k - 1));
      end
    end
    idle();
    chk("t4_cnt",   32'(b_cnt),   32'd0);
    chk("t4_empty", 32'(b_empty), 32'd1);
    chk("t4_udf",   32'(b_udf),   32'd0);
    chk("t4_ovf",   32'(b_ovf),   32'd0);

    // 5: FWFT fall-through and pop
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_out",   32'(c_out),   32'h0);
    chk("t5_rst_empty", 32'(c_empty), 32'd1);
    wr_en = 1'b1;
    din   = 16'hBEEF;
    step();
    wr_en = 1'b0;
    chk("t5_fall", 32'(c_out), 32'hBEEF);
    step();
    chk("t5_hold", 32'(c_out), 32'hBEEF);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_pop_empty", 32'(c_empty), 32'd1);
    chk("t5_pop_out",   32'(c_out),   32'h0);
    wr_en = 1'b1;
    din   = 16'h1234;
    step();
    din = 16'h5678;
    step();
    wr_en = 1'b0;
    chk("t5_head1", 32'(c_out), 32'h1234);
    rd_en = 1'b1;
    step();
    chk("t5_head2", 32'(c_out), 32'h5678);
    step();
    rd_en = 1'b0;
    chk("t5_drained", 32'(c_out), 32'h0);
    chk("t5_udf",     32'(c_udf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
